jellyvl_synctimer_timer: RTL



---
 rtl/jellyvl_synctimer_timer.sv | 112 +++++++++++
 1 files changed

// File: rtl/jellyvl_synctimer_timer.sv
// Local time base: advances current_time by NUMERATOR/DENOMINATOR units per clk, with
// single-step +/-ADJ_STEP corrections and hard overwrite. Optional adjust counters via JELLYVL_SYNCTIMER_TIMER_MONITOR_EN.
module jellyvl_synctimer_timer #(
  parameter int unsigned TIMER_WIDTH = 64,
  parameter int unsigned NUMERATOR   = 10,
  parameter int unsigned DENOMINATOR = 3,
  parameter int unsigned ADJ_STEP    = 1,
  parameter int unsigned ADJ_GUARD   = 0,
  parameter int unsigned FRAC_WIDTH  = $clog2(DENOMINATOR + 1)
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic [TIMER_WIDTH-1:0] set_time,
  input  logic                   set_valid,
  input  logic                   adjust_sign,
  input  logic                   adjust_valid,
  output logic                   adjust_ready,
  output logic [TIMER_WIDTH-1:0] current_time,
  output logic [31:0]            monitor_adj_plus,
  output logic [31:0]            monitor_adj_minus
);

  localparam int unsigned STEP_INT    = NUMERATOR / DENOMINATOR;
  localparam int unsigned STEP_REM    = NUMERATOR % DENOMINATOR;
  localparam int unsigned SUM_WIDTH   = FRAC_WIDTH + 1;
  localparam int unsigned GUARD_WIDTH = (ADJ_GUARD > 0) ? $clog2(ADJ_GUARD + 1) : 1;

  // A negative step would let time run backwards; reject such configurations.
  generate
    if ((DENOMINATOR == 0) || (ADJ_STEP * DENOMINATOR > NUMERATOR)) begin : g_param_check
      $error("jellyvl_synctimer_timer: need DENOMINATOR >= 1 and ADJ_STEP <= NUMERATOR/DENOMINATOR");
    end
  endgenerate

  logic [FRAC_WIDTH-1:0]  frac;
  logic [GUARD_WIDTH-1:0] guard;

  logic [SUM_WIDTH-1:0]   frac_sum;
  logic                   carry;
  logic                   accept;
  logic [TIMER_WIDTH-1:0] step;
  logic [TIMER_WIDTH-1:0] time_next;
  logic [FRAC_WIDTH-1:0]  frac_next;
  logic [GUARD_WIDTH-1:0] guard_next;
  logic                   ready_next;

  // Next-state: fractional step, adjust handshake with guard interval, overwrite.
  always_comb begin
    frac_sum   = SUM_WIDTH'(frac) + SUM_WIDTH'(STEP_REM);
    carry      = (frac_sum >= SUM_WIDTH'(DENOMINATOR));
    frac_next  = carry ? FRAC_WIDTH'(frac_sum - SUM_WIDTH'(DENOMINATOR)) : FRAC_WIDTH'(frac_sum);
    accept     = adjust_valid && adjust_ready;
    step       = TIMER_WIDTH'(STEP_INT) + TIMER_WIDTH'(carry);
    guard_next = guard;
    ready_next = adjust_ready;

    if (accept) begin
      step       = adjust_sign ? (step - TIMER_WIDTH'(ADJ_STEP)) : (step + TIMER_WIDTH'(ADJ_STEP));
      guard_next = GUARD_WIDTH'(ADJ_GUARD);
      ready_next = (ADJ_GUARD == 0);
    end else if (guard != '0) begin
      guard_next = guard - GUARD_WIDTH'(1);
      ready_next = (guard == GUARD_WIDTH'(1));
    end else begin
      ready_next = 1'b1;
    end

    time_next = current_time + step;

    // Overwrite wins; a simultaneous adjust is consumed but discarded.
    if (set_valid) begin
      time_next  = set_time;
      frac_next  = '0;
      guard_next = '0;
      ready_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      current_time <= '0;
      frac         <= '0;
      guard        <= '0;
      adjust_ready <= 1'b0;
    end else begin
      current_time <= time_next;
      frac         <= frac_next;
      guard        <= guard_next;
      adjust_ready <= ready_next;
    end
  end

`ifdef JELLYVL_SYNCTIMER_TIMER_MONITOR_EN
  // Saturating per-sign counters of adjusts that actually reached the time value.
  always_ff @(posedge clk) begin
    if (reset || set_valid) begin
      monitor_adj_plus  <= '0;
      monitor_adj_minus <= '0;
    end else if (accept) begin
      if (adjust_sign) begin
        if (monitor_adj_minus != '1) monitor_adj_minus <= monitor_adj_minus + 32'd1;
      end else begin
        if (monitor_adj_plus != '1) monitor_adj_plus <= monitor_adj_plus + 32'd1;
      end
    end
  end
`else
  assign monitor_adj_plus  = '0;
  assign monitor_adj_minus = '0;
`endif

endmodule
